// File: rtl/reg_dest_scoreboard.sv
// Per-register pending-write scoreboard sitting beside the ID/EX boundary.
// Counts issued-but-unretired writes and flags source hazards for the stall logic.
module reg_dest_scoreboard #(
    parameter int CNT_W = 2,
    parameter int NREG  = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       iss_valid,
    input  logic       iss_wen,
    input  logic [4:0] iss_rd,
    output logic       iss_ready,
    input  logic       wb_valid,
    input  logic [4:0] wb_rd,
    input  logic [4:0] rs_addr,
    input  logic [4:0] rt_addr,
    output logic       rs_busy,
    output logic       rt_busy,
    output logic       stall,
    input  logic       flush,
    output logic [5:0] pend_total,
    output logic       wb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_r     [1:NREG-1];
    logic [CNT_W-1:0] cnt_nxt_s [1:NREG-1];
    logic [CNT_W-1:0] cnt_ext_s [0:NREG-1];
    logic             wb_err_r;
    logic             wb_err_nxt_s;
    logic             stall_src_s;
    logic             issue_fire_s;
    logic             ret_fire_s;
    logic [5:0]       pend_s;

    // Read view of the counters with $0 hard-wired to zero
    always_comb begin
        cnt_ext_s[0] = '0;
        for (int r = 1; r < NREG; r++) begin
            cnt_ext_s[r] = cnt_r[r];
        end
    end

    // Hazard flags, issue/retire qualification and occupancy count
    always_comb begin
        rs_busy      = (rs_addr != 5'd0) && (cnt_ext_s[rs_addr] != '0);
        rt_busy      = (rt_addr != 5'd0) && (cnt_ext_s[rt_addr] != '0);
        stall_src_s  = rs_busy | rt_busy;
        // A same-cycle retire is deliberately not credited here
        iss_ready    = ~(iss_wen && (iss_rd != 5'd0) && (cnt_ext_s[iss_rd] == CNT_MAX));
        stall        = iss_valid & (stall_src_s | ~iss_ready);
        issue_fire_s = iss_valid & iss_wen & iss_ready & ~stall_src_s & (iss_rd != 5'd0);
        ret_fire_s   = wb_valid & (wb_rd != 5'd0);
        pend_s       = 6'd0;
        for (int r = 1; r < NREG; r++) begin
            pend_s = pend_s + 6'(cnt_r[r] != '0);
        end
        pend_total   = pend_s;
        wb_err       = wb_err_r;
    end

    // Next-state counters; flush wins over issue and retire but keeps the error flag
    always_comb begin
        wb_err_nxt_s = wb_err_r;
        for (int r = 1; r < NREG; r++) begin
            cnt_nxt_s[r] = cnt_r[r];
            if (flush) begin
                cnt_nxt_s[r] = '0;
            end else begin
                cnt_nxt_s[r] = cnt_r[r];
            end
            case ({issue_fire_s && (iss_rd == 5'(r)), ret_fire_s && (wb_rd == 5'(r))})
                2'b10: begin
                    if (!flush) begin
                        cnt_nxt_s[r] = cnt_r[r] + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        cnt_nxt_s[r] = '0;
                    end
                end
                2'b01: begin
                    if (cnt_r[r] == '0) begin
                        wb_err_nxt_s = 1'b1;
                    end else if (!flush) begin
                        cnt_nxt_s[r] = cnt_r[r] - {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        cnt_nxt_s[r] = '0;
                    end
                end
                default: begin
                    cnt_nxt_s[r] = cnt_nxt_s[r];
                end
            endcase
        end
    end

    // State register with asynchronous clear of all pending state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 1; r < NREG; r++) begin
                cnt_r[r] <= '0;
            end
            wb_err_r <= 1'b0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                cnt_r[r] <= cnt_nxt_s[r];
            end
            wb_err_r <= wb_err_nxt_s;
        end
    end

endmodule

// File: tb/tb_reg_dest_scoreboard.sv
// Self-checking bench: a reference model predicts outputs each cycle into a queue,
// which is drained and compared against the DUT mid-cycle.
module tb_reg_dest_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       iss_valid, iss_wen, iss_ready;
    logic [4:0] iss_rd;
    logic       wb_valid;
    logic [4:0] wb_rd, rs_addr, rt_addr;
    logic       rs_busy, rt_busy, stall, flush, wb_err;
    logic [5:0] pend_total;

    typedef struct packed {
        logic       rs_b;
        logic       rt_b;
        logic       ready;
        logic       stl;
        logic [5:0] pend;
        logic       err;
    } exp_t;

    exp_t     exp_q [$];
    int       m_cnt [0:31];
    logic     m_err;
    int       checks = 0;
    int       errors = 0;

    reg_dest_scoreboard #(.CNT_W(2), .NREG(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .iss_valid(iss_valid), .iss_wen(iss_wen), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_busy(rs_busy), .rt_busy(rt_busy), .stall(stall),
        .flush(flush), .pend_total(pend_total), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        int   p;
        e.rs_b  = (rs_addr != 5'd0) && (m_cnt[rs_addr] != 0);
        e.rt_b  = (rt_addr != 5'd0) && (m_cnt[rt_addr] != 0);
        e.ready = !(iss_wen && (iss_rd != 5'd0) && (m_cnt[iss_rd] == 3));
        e.stl   = iss_valid && (e.rs_b || e.rt_b || !e.ready);
        p = 0;
        for (int r = 1; r < 32; r++) begin
            if (m_cnt[r] != 0) p++;
        end
        e.pend  = 6'(p);
        e.err   = m_err;
        return e;
    endfunction

    task automatic model_edge();
        exp_t e;
        logic fire, retf, same;
        e    = model_out();
        fire = iss_valid && iss_wen && e.ready && !e.rs_b && !e.rt_b && (iss_rd != 5'd0);
        retf = wb_valid && (wb_rd != 5'd0);
        same = fire && retf && (iss_rd == wb_rd);
        if (retf && !same && m_cnt[wb_rd] == 0) m_err = 1'b1;
        if (flush) begin
            for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        end else if (!same) begin
            if (fire) m_cnt[iss_rd] = m_cnt[iss_rd] + 1;
            if (retf && m_cnt[wb_rd] > 0) m_cnt[wb_rd] = m_cnt[wb_rd] - 1;
        end
    endtask

    task automatic check_outputs(input string tag);
        exp_t e;
        exp_q.push_back(model_out());
        #2;
        e = exp_q.pop_front();
        chk_val({tag, "/rs_busy"}, 32'(rs_busy), 32'(e.rs_b));
        chk_val({tag, "/rt_busy"}, 32'(rt_busy), 32'(e.rt_b));
        chk_val({tag, "/iss_ready"}, 32'(iss_ready), 32'(e.ready));
        chk_val({tag, "/stall"}, 32'(stall), 32'(e.stl));
        chk_val({tag, "/pend_total"}, 32'(pend_total), 32'(e.pend));
        chk_val({tag, "/wb_err"}, 32'(wb_err), 32'(e.err));
    endtask

    task automatic step(input string tag, input logic iv, input logic iw, input logic [4:0] ird,
                        input logic wv, input logic [4:0] wrd,
                        input logic [4:0] rs, input logic [4:0] rt, input logic fl);
        iss_valid = iv; iss_wen = iw; iss_rd = ird;
        wb_valid = wv; wb_rd = wrd; rs_addr = rs; rt_addr = rt; flush = fl;
        check_outputs(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        rst_n = 1'b0; iss_valid = 1'b0; iss_wen = 1'b0; iss_rd = 5'd0;
        wb_valid = 1'b0; wb_rd = 5'd0; rs_addr = 5'd0; rt_addr = 5'd0; flush = 1'b0;
        m_err = 1'b0;
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        #1;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // issue then retire r8
        step("iss8",   1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        step("src8",   1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 5'd8, 5'd0, 1'b0);
        chk_val("src8_busy_direct", 32'(rs_busy), 32'd1);
        step("ret8",   1'b0, 1'b0, 5'd0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0);
        step("post8",  1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd8, 5'd0, 1'b0);

        // saturation of r3
        for (int i = 0; i < 3; i++) step("sat3", 1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        step("sat3_full", 1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        step("sat3_ret",  1'b0, 1'b1, 5'd3, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0);
        step("sat3_rdy",  1'b0, 1'b1, 5'd3, 1'b0, 5'd0, 5'd3, 5'd0, 1'b0);
        chk_val("sat3_ready_direct", 32'(iss_ready), 32'd1);
        step("sat3_ret2", 1'b0, 1'b0, 5'd0, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0);
        step("sat3_ret3", 1'b0, 1'b0, 5'd0, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0);
        step("sat3_idle", 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd3, 5'd0, 1'b0);

        // register zero is never tracked
        for (int i = 0; i < 5; i++) step("zero_iss", 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        step("zero_ret",  1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
        step("zero_chk",  1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

        // simultaneous issue and retire on r7, then bad retire on r9
        step("sim7_a",   1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        step("sim7_b",   1'b1, 1'b1, 5'd7, 1'b1, 5'd7, 5'd0, 5'd0, 1'b0);
        step("sim7_c",   1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd7, 1'b0);
        chk_val("sim7_rt_busy_direct", 32'(rt_busy), 32'd1);
        step("err9",     1'b0, 1'b0, 5'd0, 1'b1, 5'd9, 5'd0, 5'd7, 1'b0);
        step("err_fl",   1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd7, 1'b1);
        step("err_keep", 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd7, 1'b0);
        chk_val("err_sticky_direct", 32'(wb_err), 32'd1);

        // flush overrides a concurrent issue
        step("fl_r2",  1'b1, 1'b1, 5'd2, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) step("fl_r31", 1'b1, 1'b1, 5'd31, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        step("fl_go",  1'b1, 1'b1, 5'd4, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
        step("fl_chk", 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd4, 5'd31, 1'b0);

        // randomized traffic over a small register window
        for (int i = 0; i < 60; i++) begin
            logic fl;
            fl = ($urandom_range(0, 15) == 0);
            step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 4)),
                 fl ? 1'b0 : 1'($urandom_range(0, 1)), 5'($urandom_range(0, 4)),
                 5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)), fl);
        end

        // asynchronous reset mid-cycle with r5 holding two writes
        step("flush_pre", 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
        step("r5_a", 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        step("r5_b", 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        iss_valid = 1'b0; iss_wen = 1'b0; rs_addr = 5'd5;
        #1;
        chk_val("r5_busy_pre", 32'(rs_busy), 32'd1);
        #1;
        rst_n = 1'b0;
        m_err = 1'b0;
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        check_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
